// File: rtl/vga_frame_reader_if.sv
// Read port of the dual-port frame RAM as seen by the VGA reader.
// The reader drives the address; the RAM returns data one clock later.
interface vga_frame_reader_if;
    logic [16:0] rd_addr;
    logic [7:0]  rd_data;

    modport master (output rd_addr, input  rd_data);
    modport slave  (input  rd_addr, output rd_data);
endinterface

// File: rtl/vga_frame_reader.sv
// VGA 640x480@60 frame reader: scans the RGB332 frame RAM, upscales it by
// 2^SCALE_LOG2 and drives 4-4-4 colour with a fixed 3-cycle pipeline to the pins.
module vga_frame_reader #(
    parameter int unsigned H_VIS      = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_VIS      = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned IMG_W      = 160,
    parameter int unsigned IMG_H      = 120,
    parameter int unsigned SCALE_LOG2 = 2
) (
    input  logic                clk,
    input  logic                rst,
    vga_frame_reader_if.master  ram,
    output logic                VGA_HS,
    output logic                VGA_VS,
    output logic [3:0]          VGA_R,
    output logic [3:0]          VGA_G,
    output logic [3:0]          VGA_B,
    output logic                frame_start
);
    localparam int unsigned H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW       = $clog2(H_TOTAL);
    localparam int unsigned VW       = $clog2(V_TOTAL);
    localparam int unsigned AW       = 17;
    localparam int unsigned HS_START = H_VIS + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_VIS + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned PIX_MASK = (1 << SCALE_LOG2) - 1;

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic [HW-1:0] col;
    logic [AW-1:0] row_base;

    logic h_last_c, v_last_c, in_img_c, hs_c, vs_c, frame_c;
    logic col_step_c, row_step_c;

    // Sync flags travel active-high (1 = in sync) so a cleared pipeline means idle pins.
    logic s1_img, s1_hs, s1_vs, s1_frame;
    logic s2_img, s2_hs, s2_vs, s2_frame;

    // Decode of the current counter position.
    always_comb begin
        h_last_c   = (hcnt == HW'(H_TOTAL - 1));
        v_last_c   = (vcnt == VW'(V_TOTAL - 1));
        in_img_c   = (hcnt < HW'(H_VIS)) && (vcnt < VW'(V_VIS)) &&
                     ((hcnt >> SCALE_LOG2) < HW'(IMG_W)) &&
                     ((vcnt >> SCALE_LOG2) < VW'(IMG_H));
        hs_c       = (hcnt >= HW'(HS_START)) && (hcnt < HW'(HS_END));
        vs_c       = (vcnt >= VW'(VS_START)) && (vcnt < VW'(VS_END));
        frame_c    = (hcnt == '0) && (vcnt == '0);
        col_step_c = (hcnt < HW'(H_VIS)) && ((hcnt & HW'(PIX_MASK)) == HW'(PIX_MASK));
        row_step_c = (vcnt < VW'(V_VIS)) && ((vcnt & VW'(PIX_MASK)) == VW'(PIX_MASK));
    end

    // Raster counters plus incremental row/column address, no multiplier needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt     <= '0;
            vcnt     <= '0;
            col      <= '0;
            row_base <= '0;
        end else if (h_last_c) begin
            hcnt <= '0;
            col  <= '0;
            if (v_last_c) begin
                vcnt     <= '0;
                row_base <= '0;
            end else begin
                vcnt <= vcnt + VW'(1);
                if (row_step_c) row_base <= row_base + AW'(IMG_W);
            end
        end else begin
            hcnt <= hcnt + HW'(1);
            if (col_step_c) col <= col + HW'(1);
        end
    end

    // Three-stage pipeline: address, RAM access, pin registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram.rd_addr <= '0;
            s1_img      <= 1'b0;
            s1_hs       <= 1'b0;
            s1_vs       <= 1'b0;
            s1_frame    <= 1'b0;
            s2_img      <= 1'b0;
            s2_hs       <= 1'b0;
            s2_vs       <= 1'b0;
            s2_frame    <= 1'b0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            frame_start <= 1'b0;
        end else begin
            if (in_img_c) ram.rd_addr <= row_base + AW'(col);
            s1_img      <= in_img_c;
            s1_hs       <= hs_c;
            s1_vs       <= vs_c;
            s1_frame    <= frame_c;
            s2_img      <= s1_img;
            s2_hs       <= s1_hs;
            s2_vs       <= s1_vs;
            s2_frame    <= s1_frame;
            VGA_HS      <= ~s2_hs;
            VGA_VS      <= ~s2_vs;
            frame_start <= s2_frame;
            // RAM data is only looked at inside the image, so X outside never reaches the pins.
            if (s2_img) begin
                VGA_R <= {ram.rd_data[7:5], ram.rd_data[7]};
                VGA_G <= {ram.rd_data[4:2], ram.rd_data[4]};
                VGA_B <= {ram.rd_data[1:0], ram.rd_data[1:0]};
            end else begin
                VGA_R <= '0;
                VGA_G <= '0;
                VGA_B <= '0;
            end
        end
    end
endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader: a full-size instance and a shrunken-timing instance
// (SCALE_LOG2=1, bordered image) share clock and reset, each with a frame RAM model.
module tb_vga_frame_reader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #20 clk = ~clk;

    vga_frame_reader_if dram ();
    vga_frame_reader_if sram ();

    logic       d_hs, d_vs, d_fs, s_hs, s_vs, s_fs;
    logic [3:0] d_r, d_g, d_b, s_r, s_g, s_b;

    vga_frame_reader dut (
        .clk(clk), .rst(rst), .ram(dram.master),
        .VGA_HS(d_hs), .VGA_VS(d_vs), .VGA_R(d_r), .VGA_G(d_g), .VGA_B(d_b),
        .frame_start(d_fs)
    );

    vga_frame_reader #(
        .H_VIS(32), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_VIS(16), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .IMG_W(6), .IMG_H(3), .SCALE_LOG2(1)
    ) dut_s (
        .clk(clk), .rst(rst), .ram(sram.master),
        .VGA_HS(s_hs), .VGA_VS(s_vs), .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b),
        .frame_start(s_fs)
    );

    int n_checks = 0;
    int n_errors = 0;
    int k = 0;
    bit         ram_mode  = 1'b1;
    logic [7:0] ram_const = 8'h00;
    int de_hs = 0, de_vs = 0, de_fs = 0, de_rgb = 0, de_addr = 0;
    int se_hs = 0, se_vs = 0, se_fs = 0, se_rgb = 0, se_addr = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pat(input logic [16:0] a);
        return a[7:0] ^ {a[14:8], a[16]} ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ram_word(input logic [16:0] a);
        return ram_mode ? pat(a) : ram_const;
    endfunction

    function automatic logic [11:0] expand(input logic [7:0] d);
        return {d[7:5], d[7], d[4:2], d[4], d[1:0], d[1:0]};
    endfunction

    function automatic bit img_at(input int h, input int v, input int hv, input int vv,
                                  input int iw, input int ih, input int s);
        return (h < hv) && (v < vv) && ((h >> s) < iw) && ((v >> s) < ih);
    endfunction

    function automatic logic [16:0] exp_addr(input int h, input int v, input int iw, input int s);
        return 17'((v >> s) * iw + (h >> s));
    endfunction

    // Frame RAM models: registered read, data valid one clock after the address.
    always @(posedge clk) begin
        dram.rd_data <= ram_word(dram.rd_addr);
        sram.rd_data <= ram_word(sram.rd_addr);
    end

    // k = clock edges since reset release; pins show pixel k-3, rd_addr holds pixel k-1.
    always @(posedge clk) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    task automatic sb_eval(input int kk, input int ht, input int hv, input int hf, input int hsw,
                           input int vt, input int vv, input int vf, input int vsw,
                           input int iw, input int ih, input int s,
                           input logic hs, input logic vs, input logic fs,
                           input logic [11:0] rgb, input logic [16:0] addr,
                           inout int e_hs, inout int e_vs, inout int e_fs,
                           inout int e_rgb, inout int e_addr);
        int p, a, ph, pv, ah, av;
        logic [11:0] ergb;
        if (kk < 3) begin
            if (hs !== 1'b1) e_hs++;
            if (vs !== 1'b1) e_vs++;
            if (fs !== 1'b0) e_fs++;
            if (rgb !== 12'h000) e_rgb++;
        end else begin
            p  = kk - 3;
            ph = p % ht;
            pv = (p / ht) % vt;
            if (hs !== 1'(!((ph >= hv + hf) && (ph < hv + hf + hsw)))) e_hs++;
            if (vs !== 1'(!((pv >= vv + vf) && (pv < vv + vf + vsw)))) e_vs++;
            if (fs !== 1'((p % (ht * vt)) == 0)) e_fs++;
            ergb = img_at(ph, pv, hv, vv, iw, ih, s) ? expand(ram_word(exp_addr(ph, pv, iw, s))) : 12'h000;
            if (rgb !== ergb) e_rgb++;
        end
        if (kk == 0) begin
            if (addr !== 17'h0) e_addr++;
        end else begin
            a  = kk - 1;
            ah = a % ht;
            av = (a / ht) % vt;
            if (img_at(ah, av, hv, vv, iw, ih, s) && addr !== exp_addr(ah, av, iw, s)) e_addr++;
        end
    endtask

    // Cycle-by-cycle scoreboard for both instances, sampled mid-cycle.
    always @(negedge clk) begin
        sb_eval(k, 800, 640, 16, 96, 525, 480, 10, 2, 160, 120, 2,
                d_hs, d_vs, d_fs, {d_r, d_g, d_b}, dram.rd_addr,
                de_hs, de_vs, de_fs, de_rgb, de_addr);
        sb_eval(k, 48, 32, 4, 8, 23, 16, 2, 2, 6, 3, 1,
                s_hs, s_vs, s_fs, {s_r, s_g, s_b}, sram.rd_addr,
                se_hs, se_vs, se_fs, se_rgb, se_addr);
    end

    task automatic wait_k(input int target);
        int guard = 0;
        while (k != target && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (k != target) check("wait_timeout", 32'(k), 32'(target));
    endtask

    // Holds reset for 3 edges; returns at a mid-cycle point still inside reset.
    task automatic enter_reset(input bit mode, input logic [7:0] c);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        ram_mode  = mode;
        ram_const = c;
        @(negedge clk);
    endtask

    task automatic leave_reset;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, k=%0d", k);
        $fatal(1, "watchdog");
    end

    initial begin
        // Phase 1: address pattern RAM, timing and address sequence.
        enter_reset(1'b1, 8'h00);
        leave_reset();
        wait_k(2);    check("fs_before", 32'(d_fs), 32'd0);
                      check("hs_reset_tail", 32'(d_hs), 32'd1);
        wait_k(3);    check("fs_first_pixel", 32'(d_fs), 32'd1);
        wait_k(4);    check("addr_h3_v0", 32'(dram.rd_addr), 32'd0);
        wait_k(5);    check("addr_h4_v0", 32'(dram.rd_addr), 32'd1);
        wait_k(252);  check("s_addr_last_img", 32'(sram.rd_addr), 32'd17);
        wait_k(640);  check("addr_h639_v0", 32'(dram.rd_addr), 32'd159);
        wait_k(658);  check("hs_p655", 32'(d_hs), 32'd1);
        wait_k(659);  check("hs_p656", 32'(d_hs), 32'd0);
        wait_k(754);  check("hs_p751", 32'(d_hs), 32'd0);
        wait_k(755);  check("hs_p752", 32'(d_hs), 32'd1);
        wait_k(802);  check("addr_h1_v1", 32'(dram.rd_addr), 32'd0);
        wait_k(866);  check("s_vs_line17", 32'(s_vs), 32'd1);
        wait_k(867);  check("s_vs_line18", 32'(s_vs), 32'd0);
        wait_k(1106); check("s_fs_before_wrap", 32'(s_fs), 32'd0);
        wait_k(1107); check("s_fs_frame1", 32'(s_fs), 32'd1);
        wait_k(3201); check("addr_h0_v4", 32'(dram.rd_addr), 32'd160);
        wait_k(3206); check("addr_h5_v4", 32'(dram.rd_addr), 32'd161);
        wait_k(4010);

        // Phase 2: mid-line reset, constant E3.
        enter_reset(1'b0, 8'hE3);
        check("rst_hs", 32'(d_hs), 32'd1);
        check("rst_vs", 32'(d_vs), 32'd1);
        check("rst_rgb", 32'({d_r, d_g, d_b}), 32'h000);
        check("rst_addr", 32'(dram.rd_addr), 32'd0);
        check("rst_fs", 32'(d_fs), 32'd0);
        leave_reset();
        wait_k(2);   check("rst_fs_k2", 32'(d_fs), 32'd0);
        wait_k(3);   check("rst_fs_k3", 32'(d_fs), 32'd1);
        wait_k(13);  check("rgb_E3", 32'({d_r, d_g, d_b}), 32'hF0F);
        wait_k(900);

        // Phases 3-4: remaining colour mappings.
        enter_reset(1'b0, 8'h1C);
        leave_reset();
        wait_k(13);  check("rgb_1C", 32'({d_r, d_g, d_b}), 32'h0F0);
        enter_reset(1'b0, 8'h49);
        leave_reset();
        wait_k(13);  check("rgb_49", 32'({d_r, d_g, d_b}), 32'h445);

        // Phase 5: all-ones RAM, blanking and border must stay black.
        enter_reset(1'b0, 8'hFF);
        leave_reset();
        wait_k(13);  check("rgb_FF_img", 32'({d_r, d_g, d_b}), 32'hFFF);
        wait_k(15);  check("s_border_right", 32'({s_r, s_g, s_b}), 32'h000);
        wait_k(254); check("s_img_corner", 32'({s_r, s_g, s_b}), 32'hFFF);
        wait_k(291); check("s_border_below", 32'({s_r, s_g, s_b}), 32'h000);
        wait_k(643); check("hblank_p640", 32'({d_r, d_g, d_b}), 32'h000);
        wait_k(824); check("s_vblank", 32'({s_r, s_g, s_b}), 32'h000);
        wait_k(1150);

        check("sb_d_hs", 32'(de_hs), 32'd0);
        check("sb_d_vs", 32'(de_vs), 32'd0);
        check("sb_d_fs", 32'(de_fs), 32'd0);
        check("sb_d_rgb", 32'(de_rgb), 32'd0);
        check("sb_d_addr", 32'(de_addr), 32'd0);
        check("sb_s_hs", 32'(se_hs), 32'd0);
        check("sb_s_vs", 32'(se_vs), 32'd0);
        check("sb_s_fs", 32'(se_fs), 32'd0);
        check("sb_s_rgb", 32'(se_rgb), 32'd0);
        check("sb_s_addr", 32'(se_addr), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/vga_frame_reader.md
Name: vga_frame_reader

Overview:
- Downstream consumer of the camera frame buffer: reads RGB332 pixels from the read port of the dual-port frame RAM.
- The camera capture stage fills the same RAM through its write port (17-bit address, 8-bit data).
- Generates 640x480@60 VGA timing from a 25 MHz pixel clock and upscales the stored image by 2^SCALE_LOG2 in both axes.
- Expands RGB332 to 4-4-4 for the board DAC.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- IMG_W, 160, stored image width in pixels
- IMG_H, 120, stored image height in lines
- SCALE_LOG2, 2, upscale factor exponent (each stored pixel is 4x4 screen pixels)

Ports:
- clk  in  1  25 MHz pixel clock
- rst  in  1  synchronous, active-high reset
- rd_addr  out  17  frame RAM read address (linear, row-major)
- rd_data  in  8  frame RAM read data {R[2:0],G[2:0],B[1:0]}, valid one clk after rd_addr
- VGA_HS  out  1  horizontal sync, active low
- VGA_VS  out  1  vertical sync, active low
- VGA_R  out  4  red
- VGA_G  out  4  green
- VGA_B  out  4  blue
- frame_start  out  1  one-cycle pulse, first pixel of frame at pins

Behaviour:
- One clock; reset is synchronous and active-high on clk.
- Reset values: VGA_HS=1, VGA_VS=1, RGB=0, rd_addr=0, frame_start=0, all counters and pipeline registers=0.

Counters:
- hcnt runs 0..H_TOTAL-1, where H_TOTAL = 800.
- vcnt increments when hcnt wraps and runs 0..V_TOTAL-1, where V_TOTAL = 525.
- Both wrap to 0 after the last value.
- Active area: hcnt<H_VIS && vcnt<V_VIS.
- Sync windows:
  - HS low for H_VIS+H_FP <= hcnt < H_VIS+H_FP+H_SYNC.
  - VS low for V_VIS+V_FP <= vcnt < V_VIS+V_FP+V_SYNC.

Image window:
- in_img = active && (hcnt>>SCALE_LOG2)<IMG_W && (vcnt>>SCALE_LOG2)<IMG_H.

Address generation (no multiplier):
- col increments every 2^SCALE_LOG2 active pixels.
- row_base advances by IMG_W every 2^SCALE_LOG2 lines.
- Both are cleared at frame start; col is also cleared at line start.
- rd_addr = row_base + col, registered.
- Outside in_img, rd_addr holds its last value (don't care).
- Maximum address IMG_W*IMG_H-1 must fit in 17 bits (76799 max).

Pipeline, fixed 3-cycle latency from counter state to pins:
- Stage 1 (cycle n+1): rd_addr registered. Active, in_img, HS, VS and frame flag are registered alongside.
- Stage 2 (cycle n+2): RAM returns rd_data; control flags are delayed one more stage.
- Stage 3 (cycle n+3): pin registers load.
- HS/VS/RGB/frame_start at pins always correspond to the same (hcnt,vcnt).

Colour expansion:
- R={d[7:5],d[7]}
- G={d[4:2],d[4]}
- B={d[1:0],d[1:0]}
- RGB forced to 0 when delayed in_img is 0, which covers blanking and the border outside the image.

frame_start:
- 1 for exactly one cycle, aligned with pixel (0,0) at pins.
- Period V_TOTAL*H_TOTAL = 420000 clk.

Boundary and simultaneous cases:
- Frame wrap: hcnt and vcnt wrapping on the same edge clears col and row_base on that edge. The first address of the new frame is 0.
- Reset mid-line: the next cycle after rst deassertion starts at hcnt=vcnt=0. Pipeline contents are discarded; the pins show reset values for 3 cycles, then frame 0 timing begins.
- rd_data is ignored, and no X propagates to the pins, whenever delayed in_img=0.
- The reader never writes RAM and has no handshake with the capture stage. Tearing during capture is accepted.

Test Plan:
- Reset: assert rst for 3 clk mid-frame -> HS=VS=1, RGB=0, rd_addr=0, frame_start=0. After release, frame_start pulses exactly 3 clk later.
- Line timing: count clocks at pins -> HS low 96 clk starting at pin-cycle 656 of each 800-clk line. VS low for lines 490-491. 420000 clk between frame_start pulses.
- Address sequence: line 0 -> rd_addr 0,0,0,0,1,1,1,1,...,159. Lines 1-3 repeat 0..159. Line 4 starts at 160. Line 476 ends at 19199.
- Colour mapping: RAM model returns 8'hE3 -> R=F,G=0,B=F. 8'h1C -> R=0,G=F,B=0. 8'h49 -> R=4,G=4,B=5.
- Blanking: RAM model returns 8'hFF constantly -> RGB=0 for pin cycles 640..799 of every line and all of lines 480..524.
- Border: SCALE_LOG2=1, IMG_W=160, IMG_H=120 -> image fills hcnt<320, vcnt<240. RGB=0 elsewhere in the active area.
